// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: command FSM states and the
// read-tag record that remembers who owns each outstanding read burst.
package sdram_arb_pkg;

    // Tag burstcount field is wide enough for any BURST_W up to 16 bits.
    localparam int TAG_BC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WBURST = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                id;
        logic [TAG_BC_W-1:0] burstcount;
    } rd_tag_t;

    // A burstcount of zero is a single-beat transfer.
    function automatic logic [TAG_BC_W-1:0] eff_burst(input logic [TAG_BC_W-1:0] bc);
        return (bc == {TAG_BC_W{1'b0}}) ? TAG_BC_W'(1) : bc;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Small FIFO of read tags, one entry per read burst issued to the master
// port and not yet fully returned. DEPTH must be a power of two >= 2.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  rd_tag_t push_tag,
    input  logic    pop,
    output rd_tag_t head_tag,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    rd_tag_t          mem_q [DEPTH];
    rd_tag_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == {(PTR_W+1){1'b0}});
    assign head_tag = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update; a pop frees the slot a same-cycle push may reuse.
    always_comb begin
        do_push_s = push & (~full | pop);
        do_pop_s  = pop & ~empty;
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one SDRAM controller port.
// Commands are granted round-robin and muxed through combinationally; write
// bursts hold the grant until their last beat. Read returns are steered by a
// tag FIFO independently of the command side, so reads overlap writes.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 29,
    parameter int BURST_W   = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic [BURST_W-1:0]  s0_burstcount,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [BURST_W-1:0]  s1_burstcount,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [BURST_W-1:0]  m_burstcount,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err_orphan_rdv
);

    arb_state_e         state_q, state_d;
    logic               grant_q, grant_d;          // also the "last granted" memory
    logic [BURST_W-1:0] beats_left_q, beats_left_d;
    logic [BURST_W-1:0] rd_cnt_q, rd_cnt_d;
    logic               err_q, err_d;

    logic               req0_s, req1_s;
    logic               sel_read_s, sel_write_s;
    logic [BURST_W-1:0] sel_bc_s;
    logic               own_wait_s;
    logic               tag_push_s, tag_pop_s, tag_full_s, tag_empty_s;
    rd_tag_t            push_tag_s, head_tag_s;
    logic               rdv_ok_s, head_last_s;

    assign req0_s      = s0_read | s0_write;
    assign req1_s      = s1_read | s1_write;
    assign sel_read_s  = grant_q ? s1_read       : s0_read;
    assign sel_write_s = grant_q ? s1_write      : s0_write;
    assign sel_bc_s    = grant_q ? s1_burstcount : s0_burstcount;

    assign push_tag_s.id         = grant_q;
    assign push_tag_s.burstcount = TAG_BC_W'(sel_bc_s);

    sdram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (tag_push_s),
        .push_tag (push_tag_s),
        .pop      (tag_pop_s),
        .head_tag (head_tag_s),
        .full     (tag_full_s),
        .empty    (tag_empty_s)
    );

    // Command FSM state, grant and write-burst beat registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b1;
            beats_left_q <= {BURST_W{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Next-state: round-robin arbitration in IDLE, read/write acceptance in CMD, beat counting in WBURST.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beats_left_d = beats_left_q;
        tag_push_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_s & req1_s) begin
                    grant_d = ~grant_q;
                    state_d = ST_CMD;
                end else if (req0_s) begin
                    grant_d = 1'b0;
                    state_d = ST_CMD;
                end else if (req1_s) begin
                    grant_d = 1'b1;
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (sel_read_s) begin
                    if (~tag_full_s & ~m_waitrequest) begin
                        tag_push_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_CMD;
                    end
                end else if (sel_write_s) begin
                    if (m_waitrequest) begin
                        state_d = ST_CMD;
                    end else if (sel_bc_s <= BURST_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beats_left_d = sel_bc_s - BURST_W'(1);
                        state_d      = ST_WBURST;
                    end
                end else begin
                    // Requester withdrew before acceptance.
                    state_d = ST_IDLE;
                end
            end
            ST_WBURST: begin
                if (sel_write_s & ~m_waitrequest) begin
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q <= BURST_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WBURST;
                    end
                end else begin
                    state_d = ST_WBURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command outputs: granted requester muxed straight through; reads held off while the tag FIFO is full.
    always_comb begin
        m_address    = grant_q ? s1_address    : s0_address;
        m_burstcount = sel_bc_s;
        m_writedata  = grant_q ? s1_writedata  : s0_writedata;
        m_byteenable = grant_q ? s1_byteenable : s0_byteenable;
        m_read       = 1'b0;
        m_write      = 1'b0;
        own_wait_s   = 1'b1;
        case (state_q)
            ST_CMD: begin
                m_read  = sel_read_s & ~tag_full_s;
                m_write = sel_write_s & ~sel_read_s;
                if (sel_read_s & tag_full_s) begin
                    own_wait_s = 1'b1;
                end else begin
                    own_wait_s = m_waitrequest;
                end
            end
            ST_WBURST: begin
                m_write    = sel_write_s;
                own_wait_s = m_waitrequest;
            end
            default: begin
                own_wait_s = 1'b1;
            end
        endcase
        s0_waitrequest = grant_q  ? 1'b1 : own_wait_s;
        s1_waitrequest = !grant_q ? 1'b1 : own_wait_s;
    end

    // Read return steering: head tag owns the beat; the last beat of its burst pops it.
    always_comb begin
        rdv_ok_s    = m_readdatavalid & ~tag_empty_s;
        head_last_s = (TAG_BC_W'(rd_cnt_q) + TAG_BC_W'(1)) >= eff_burst(head_tag_s.burstcount);
        tag_pop_s   = rdv_ok_s & head_last_s;
        if (rdv_ok_s) begin
            rd_cnt_d = head_last_s ? {BURST_W{1'b0}} : (rd_cnt_q + BURST_W'(1));
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
        err_d = err_q | (m_readdatavalid & tag_empty_s);
    end

    // Read beat counter and sticky orphan-return flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= {BURST_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = rdv_ok_s & ~head_tag_s.id;
    assign s1_readdatavalid = rdv_ok_s &  head_tag_s.id;
    assign err_orphan_rdv   = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: requester drivers fed from command queues,
// a per-cycle transaction-level model of read ownership and mux behaviour,
// and directed scenarios with hand-computed cycle/data expectations.
module tb_sdram_port_arbiter;

    localparam int DATA_W = 64, ADDR_W = 29, BURST_W = 8, TAG_DEPTH = 4;
    localparam int BE_W = DATA_W / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [ADDR_W-1:0] s0_address = '0, s1_address = '0, m_address;
    logic [BURST_W-1:0] s0_burstcount = '0, s1_burstcount = '0, m_burstcount;
    logic s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [DATA_W-1:0] s0_writedata = '0, s1_writedata = '0, m_writedata;
    logic [BE_W-1:0] s0_byteenable = '0, s1_byteenable = '0, m_byteenable;
    logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic m_read, m_write;
    logic m_waitrequest = 1'b0;
    logic [DATA_W-1:0] m_readdata = '0;
    logic m_readdatavalid = 1'b0;
    logic err_orphan_rdv;

    sdram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s0_address), .s0_burstcount(s0_burstcount), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_burstcount(s1_burstcount), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable), .s1_waitrequest(s1_waitrequest),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .err_orphan_rdv(err_orphan_rdv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int eff(input int bc);
        return (bc == 0) ? 1 : bc;
    endfunction

    // ---------------- requester drivers ----------------
    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        int                bc;
        logic [63:0]       data;
    } cmd_t;
    cmd_t q0[$];
    cmd_t q1[$];
    int beat0 = 0, beat1 = 0;
    bit acc0, acc1;

    initial begin
        forever begin
            @(negedge clk);
            acc0 = reset_n && (s0_read || s0_write) && !s0_waitrequest;
            acc1 = reset_n && (s1_read || s1_write) && !s1_waitrequest;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                q0.delete(); q1.delete(); beat0 = 0; beat1 = 0;
            end else begin
                if (acc0 && q0.size() > 0) begin
                    if (q0[0].wr && beat0 + 1 < eff(q0[0].bc)) beat0++;
                    else begin beat0 = 0; void'(q0.pop_front()); end
                end
                if (acc1 && q1.size() > 0) begin
                    if (q1[0].wr && beat1 + 1 < eff(q1[0].bc)) beat1++;
                    else begin beat1 = 0; void'(q1.pop_front()); end
                end
            end
            if (q0.size() > 0) begin
                s0_read = !q0[0].wr; s0_write = q0[0].wr; s0_address = q0[0].addr;
                s0_burstcount = BURST_W'(q0[0].bc); s0_writedata = q0[0].data + 64'(beat0);
                s0_byteenable = 8'hFF;
            end else begin
                s0_read = 1'b0; s0_write = 1'b0;
            end
            if (q1.size() > 0) begin
                s1_read = !q1[0].wr; s1_write = q1[0].wr; s1_address = q1[0].addr;
                s1_burstcount = BURST_W'(q1[0].bc); s1_writedata = q1[0].data + 64'(beat1);
                s1_byteenable = 8'h0F;
            end else begin
                s1_read = 1'b0; s1_write = 1'b0;
            end
        end
    end

    // ---------------- model and per-cycle compare ----------------
    // Outstanding read bursts in issue order: owner and beats still to come.
    int mq_id[$];
    int mq_left[$];
    bit exp_err = 1'b0;
    int rd_log_cyc[$], rd_log_id[$];
    int wr_log_cyc[$], wr_log_id[$];
    logic [63:0] wr_log_data[$];
    int rdv_log_id[$];
    logic [63:0] rdv_log_data[$];

    initial begin
        int id;
        bit orphan;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_m_read", m_read, 0);
                chk("rst_m_write", m_write, 0);
                chk("rst_waitreq", {s0_waitrequest, s1_waitrequest}, 2'b11);
                chk("rst_rdv", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
                mq_id.delete(); mq_left.delete(); exp_err = 1'b0;
            end else begin
                orphan = 1'b0;
                chk("rdata_mirror", {s0_readdata ^ m_readdata, s1_readdata ^ m_readdata} == '0, 1);
                if (m_readdatavalid) begin
                    if (mq_id.size() == 0) begin
                        chk("orphan_drop", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
                        orphan = 1'b1;
                    end else begin
                        id = mq_id[0];
                        chk("rdv_route", {s1_readdatavalid, s0_readdatavalid}, (id == 1) ? 2'b10 : 2'b01);
                        rdv_log_id.push_back(id);
                        rdv_log_data.push_back(m_readdata);
                        mq_left[0] = mq_left[0] - 1;
                        if (mq_left[0] == 0) begin
                            void'(mq_id.pop_front()); void'(mq_left.pop_front());
                        end
                    end
                end else begin
                    chk("rdv_quiet", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
                end
                chk("err_orphan", err_orphan_rdv, exp_err);
                if (orphan) exp_err = 1'b1;
                if (m_read || m_write) begin
                    id = m_address[ADDR_W-1] ? 1 : 0;
                    chk("one_strobe", m_read && m_write, 0);
                    chk("other_wait", id ? s0_waitrequest : s1_waitrequest, 1);
                    chk("own_wait", id ? s1_waitrequest : s0_waitrequest, m_waitrequest);
                    chk("mux_bc", m_burstcount, id ? s1_burstcount : s0_burstcount);
                    chk("mux_wdata", m_writedata, id ? s1_writedata : s0_writedata);
                    chk("mux_be", m_byteenable, id ? s1_byteenable : s0_byteenable);
                    if (!m_waitrequest && m_read) begin
                        mq_id.push_back(id); mq_left.push_back(eff(int'(m_burstcount)));
                        rd_log_cyc.push_back(cyc); rd_log_id.push_back(id);
                    end
                    if (!m_waitrequest && m_write) begin
                        wr_log_cyc.push_back(cyc); wr_log_id.push_back(id); wr_log_data.push_back(m_writedata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    task automatic nstep();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        nstep(); nstep();
        chk("reset_m_read", m_read, 0);
        chk("reset_m_write", m_write, 0);
        chk("reset_s0_wait", s0_waitrequest, 1);
        chk("reset_s1_wait", s1_waitrequest, 1);
        chk("reset_err", err_orphan_rdv, 0);
        reset_n = 1'b1;
        nstep(); nstep();
    endtask

    task automatic rdv_burst(input int n, input logic [63:0] base, output int first_cyc);
        @(posedge clk);
        #1;
        first_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            m_readdatavalid = 1'b1;
            m_readdata = base + 64'(i);
            @(posedge clk);
            #1;
        end
        m_readdatavalid = 1'b0;
    endtask

    task automatic wait_reads(input int target, input int budget, input string nm);
        for (int i = 0; i < budget && rd_log_cyc.size() < target; i++) nstep();
        chk(nm, rd_log_cyc.size() >= target, 1);
    endtask

    function automatic cmd_t mk(input bit wr, input bit id, input int a, input int bc, input logic [63:0] d);
        cmd_t c;
        c.wr = wr; c.addr = {id, 28'(a)}; c.bc = bc; c.data = d;
        return c;
    endfunction

    initial begin
        int k, n0, nw, j, viol;
        int exp_ids[5];
        exp_ids = '{0, 0, 1, 1, 1};
        do_reset();

        // A: simultaneous reads after reset -> s0 then s1, m_read two cycles apart.
        nstep();
        k = cyc + 1; n0 = rd_log_cyc.size();
        q0.push_back(mk(1'b0, 1'b0, 'h10, 1, 64'h0));
        q1.push_back(mk(1'b0, 1'b1, 'h20, 1, 64'h0));
        wait_reads(n0 + 2, 20, "A_timeout");
        if (rd_log_cyc.size() >= n0 + 2) begin
            chk("A_first_id", rd_log_id[n0], 0);
            chk("A_first_cyc", rd_log_cyc[n0], k + 1);
            chk("A_second_id", rd_log_id[n0+1], 1);
            chk("A_second_cyc", rd_log_cyc[n0+1], k + 3);
        end
        rdv_burst(2, 64'hA0, j);
        nstep();

        // B: s0 write burst 4 while s1 waits; s1 granted right after.
        nstep();
        k = cyc + 1; n0 = rd_log_cyc.size(); nw = wr_log_cyc.size(); viol = 0;
        q0.push_back(mk(1'b1, 1'b0, 'h30, 4, 64'hB000));
        q1.push_back(mk(1'b0, 1'b1, 'h40, 1, 64'h0));
        for (int i = 0; i < 30 && rd_log_cyc.size() < n0 + 1; i++) begin
            nstep();
            if (cyc >= k && cyc <= k + 5 && !s1_waitrequest) viol++;
        end
        chk("B_timeout", rd_log_cyc.size() >= n0 + 1, 1);
        chk("B_s1_stalled", viol, 0);
        chk("B_beats", wr_log_cyc.size() - nw, 4);
        if (wr_log_cyc.size() - nw == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("B_beat_cyc", wr_log_cyc[nw+i], k + 1 + i);
                chk("B_beat_data", wr_log_data[nw+i], 64'hB000 + 64'(i));
            end
        end
        if (rd_log_cyc.size() >= n0 + 1) chk("B_s1_cyc", rd_log_cyc[n0], k + 6);
        rdv_burst(1, 64'hB1, j);
        nstep();

        // C: five single reads with no returns; fifth stalls until one tag is popped.
        nstep();
        k = cyc + 1; n0 = rd_log_cyc.size();
        for (int i = 0; i < 5; i++) q0.push_back(mk(1'b0, 1'b0, 'h50 + i, (i == 2) ? 0 : 1, 64'h0));
        while (cyc < k + 12) nstep();
        chk("C_four_issued", rd_log_cyc.size() - n0, 4);
        chk("C_stall_m_read", m_read, 0);
        chk("C_stall_wait", s0_waitrequest, 1);
        rdv_burst(1, 64'hC0, j);
        wait_reads(n0 + 5, 10, "C_timeout");
        if (rd_log_cyc.size() >= n0 + 5) chk("C_fifth_cyc", rd_log_cyc[n0+4], j + 1);
        rdv_burst(4, 64'hC1, j);
        nstep();

        // D: s0 read burst 2 then s1 read burst 3; returns split 2/3 in order.
        nstep();
        n0 = rd_log_cyc.size();
        q0.push_back(mk(1'b0, 1'b0, 'h60, 2, 64'h0));
        nstep();
        q1.push_back(mk(1'b0, 1'b1, 'h70, 3, 64'h0));
        wait_reads(n0 + 2, 20, "D_timeout");
        nw = rdv_log_id.size();
        rdv_burst(5, 64'hD0, j);
        nstep();
        chk("D_beats", rdv_log_id.size() - nw, 5);
        if (rdv_log_id.size() - nw == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("D_owner", rdv_log_id[nw+i], exp_ids[i]);
                chk("D_data", rdv_log_data[nw+i], 64'hD0 + 64'(i));
            end
        end

        // E: orphan return sets a sticky error that only reset clears.
        do_reset();
        rdv_burst(1, 64'hE0, j);
        nstep();
        chk("E_err_set", err_orphan_rdv, 1);
        n0 = rd_log_cyc.size();
        q0.push_back(mk(1'b0, 1'b0, 'h80, 1, 64'h0));
        wait_reads(n0 + 1, 20, "E_timeout");
        rdv_burst(1, 64'hE1, j);
        nstep(); nstep();
        chk("E_err_sticky", err_orphan_rdv, 1);

        // F: reset in the middle of a write burst 8 with a read outstanding.
        do_reset();
        n0 = rd_log_cyc.size();
        q1.push_back(mk(1'b0, 1'b1, 'h90, 1, 64'h0));
        wait_reads(n0 + 1, 20, "F_read_timeout");
        nw = wr_log_cyc.size();
        q0.push_back(mk(1'b1, 1'b0, 'hA0, 8, 64'hF00));
        for (int i = 0; i < 30 && wr_log_cyc.size() < nw + 2; i++) nstep();
        chk("F_two_beats", wr_log_cyc.size() - nw, 2);
        @(posedge clk);
        #2;
        chk("F_beat3_write", m_write, 1);
        chk("F_beat3_data", m_writedata, 64'hF02);
        reset_n = 1'b0;
        #1;
        chk("F_rst_m_write", m_write, 0);
        chk("F_rst_s0_wait", s0_waitrequest, 1);
        nstep(); nstep();
        reset_n = 1'b1;
        nstep(); nstep();
        chk("F_err_clear", err_orphan_rdv, 0);
        rdv_burst(1, 64'hF9, j);
        nstep();
        chk("F_late_return_err", err_orphan_rdv, 1);
        nstep();
        k = cyc + 1; n0 = rd_log_cyc.size();
        q0.push_back(mk(1'b0, 1'b0, 'hB0, 1, 64'h0));
        q1.push_back(mk(1'b0, 1'b1, 'hC0, 1, 64'h0));
        wait_reads(n0 + 2, 20, "F_rearb_timeout");
        if (rd_log_cyc.size() >= n0 + 2) begin
            chk("F_rearb_first", rd_log_id[n0], 0);
            chk("F_rearb_first_cyc", rd_log_cyc[n0], k + 1);
            chk("F_rearb_second", rd_log_id[n0+1], 1);
        end
        rdv_burst(2, 64'hFA, j);
        nstep();
        chk("final_outstanding", mq_id.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
